// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the dmem load/store front end: access sizes, FSM state encoding
// and the alignment rule used at request accept.
package dmem_access_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B    = 2'b00,
    MEM_H    = 2'b01,
    MEM_W    = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_e;

  typedef logic [1:0] dau_state_e;

  localparam dau_state_e IDLE   = 2'd0;
  localparam dau_state_e ACCESS = 2'd1;
  localparam dau_state_e WRITE  = 2'd2;
  localparam dau_state_e RESP   = 2'd3;

  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_B:   bad = 1'b0;
      MEM_H:   bad = off[0];
      MEM_W:   bad = |off;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_access_unit_mem_lane_align.sv
// Lane steering between a 32-bit dmem word and byte/half/word accesses:
// load extraction with sign/zero extension and read-modify-write merge for stores.
module mem_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ext_data,
  output logic [31:0] merged_data
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] wshift;
  logic [31:0] mask;

  always_comb begin
    sh       = {off, 3'b000};
    shifted  = rdata >> sh;
    wshift   = wdata << sh;
    ext_data = rdata;
    mask     = 32'hFFFF_FFFF;
    case (size)
      MEM_B: begin
        ext_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        mask     = 32'h0000_00FF << sh;
      end
      MEM_H: begin
        // half offsets are only ever 0 or 2 here, so the byte shift lands on a half lane
        ext_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        mask     = 32'h0000_FFFF << sh;
      end
      default: begin
        ext_data = rdata;
        mask     = 32'hFFFF_FFFF;
      end
    endcase
    merged_data = (rdata & ~mask) | (wshift & mask);
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Load/store front end for the word-only dmem: request handshake, error check,
// lane extraction and read-modify-write for sub-word stores.
//
//  state  | meaning
//  IDLE   | req_ready high, waiting for a request
//  ACCESS | mem_addr valid; load data captured, word store written, or merge word built
//  WRITE  | merged word written back for a sub-word store
//  RESP   | resp_valid pulse, then back to IDLE
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  dau_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        req_err;
  logic [31:0] ext_data;
  logic [31:0] merged_data;

  mem_lane_align u_align (
    .rdata       (mem_rdata),
    .wdata       (wdata_q),
    .off         (off_q),
    .size        (size_q),
    .sign_ext    (sign_q),
    .ext_data    (ext_data),
    .merged_data (merged_data)
  );

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_err   = size_misaligned(req_size, req_addr[1:0]) ||
                     ({2'b00, req_addr[31:2]} >= DEPTH_WORDS);

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          sign_d  = req_signed;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
            state_d      = RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_size == MEM_W)) mem_wdata_d = req_wdata;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        resp_err_d = 1'b0;
        if (!we_q) begin
          resp_rdata_d = ext_data;
          state_d      = RESP;
        end else if (size_q == MEM_W) begin
          resp_rdata_d = 32'h0;
          state_d      = RESP;
        end else begin
          mem_wdata_d = merged_data;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        state_d      = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // reset gates the write strobe combinationally so a reset edge can never commit a partial store
  assign mem_we = !reset &&
                  (((state_q == ACCESS) && we_q && (size_q == MEM_W)) || (state_q == WRITE));

  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: vector table of single requests against a
// behavioural dmem, plus reset-in-WRITE and back-to-back load sequences.
module tb_dmem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];
  logic        mem_init;

  int checks;
  int failures;

  dmem_access_unit #(.DEPTH_WORDS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]  <= 32'h8899_AABB;
      mem[63] <= 32'hA1B2_C3D4;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
    int          idx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic err,
                     input logic [31:0] rdata, input int lat, input int nwe,
                     input int idx, input logic [31:0] word);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.lat = lat; v.nwe = nwe; v.idx = idx; v.word = word;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
  endtask

  // request fields are scrambled right after accept so any late use of them shows up
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int nwe, output logic err,
                         output logic [31:0] rdata, output logic ready_ok,
                         output logic one_cycle);
    @(negedge clk);
    ready_ok  = req_ready;
    req_valid = 1'b1;
    drive(we, size, sgn, addr, wdata);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drive(~we, 2'b11, ~sgn, 32'hFFFF_FFFF, ~wdata);
    lat = -1; nwe = 0; err = 1'b0; rdata = 32'h0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (resp_valid) begin
        lat = n; err = resp_err; rdata = resp_rdata;
        break;
      end
    end
    @(negedge clk);
    one_cycle = !resp_valid;
    if (mem_we) nwe++;
  endtask

  int          lat, nwe;
  logic        err, ready_ok, one_cycle;
  logic [31:0] rdata;
  int          acc_cyc[3];
  int          rsp_cyc[3];
  logic [31:0] rsp_dat[3];
  int          nacc, nrsp;

  initial begin
    checks = 0; failures = 0;
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    reset = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", {31'b0, req_ready}, 32'h0);
    chk("rst_mem_we_low", {31'b0, mem_we}, 32'h0);
    reset = 1'b0; mem_init = 1'b0;
    #1;
    chk("rst_ready_high", {31'b0, req_ready}, 32'h1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    //  we    size   sgn   addr        wdata         err   rdata         lat nwe idx word
    add(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         1'b0, 32'h8899AABB, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b00, 1'b1, 32'h11,  32'h0,         1'b0, 32'hFFFFFFAA, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b00, 1'b0, 32'h11,  32'h0,         1'b0, 32'h000000AA, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b01, 1'b1, 32'h12,  32'h0,         1'b0, 32'hFFFF8899, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b01, 1'b0, 32'h10,  32'h0,         1'b0, 32'h0000AABB, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b00, 1'b1, 32'h10,  32'h0,         1'b0, 32'hFFFFFFBB, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b00, 1'b0, 32'h13,  32'h0,         1'b0, 32'h00000088, 2, 0, 4,  32'h8899AABB);
    add(1'b0, 2'b01, 1'b1, 32'h10,  32'h0,         1'b0, 32'hFFFFAABB, 2, 0, 4,  32'h8899AABB);
    add(1'b1, 2'b00, 1'b0, 32'h13,  32'h12345655,  1'b0, 32'h0,        3, 1, 4,  32'h5599AABB);
    add(1'b1, 2'b01, 1'b0, 32'h10,  32'h00001234,  1'b0, 32'h0,        3, 1, 4,  32'h55991234);
    add(1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         1'b0, 32'h55991234, 2, 0, 4,  32'h55991234);
    add(1'b0, 2'b01, 1'b1, 32'h11,  32'h0,         1'b1, 32'h0,        1, 0, 4,  32'h55991234);
    add(1'b1, 2'b10, 1'b0, 32'h12,  32'hFFFFFFFF,  1'b1, 32'h0,        1, 0, 4,  32'h55991234);
    add(1'b1, 2'b11, 1'b0, 32'h10,  32'hFFFFFFFF,  1'b1, 32'h0,        1, 0, 4,  32'h55991234);
    add(1'b1, 2'b10, 1'b0, 32'h100, 32'hFFFFFFFF,  1'b1, 32'h0,        1, 0, 0,  32'h00000000);
    add(1'b1, 2'b10, 1'b0, 32'h14,  32'hDEADBEEF,  1'b0, 32'h0,        2, 1, 5,  32'hDEADBEEF);
    add(1'b0, 2'b10, 1'b0, 32'h14,  32'h0,         1'b0, 32'hDEADBEEF, 2, 0, 5,  32'hDEADBEEF);
    add(1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,         1'b0, 32'hA1B2C3D4, 2, 0, 63, 32'hA1B2C3D4);
    add(1'b0, 2'b00, 1'b1, 32'hFF,  32'h0,         1'b0, 32'hFFFFFFA1, 2, 0, 63, 32'hA1B2C3D4);
    add(1'b1, 2'b00, 1'b0, 32'hFE,  32'h000000EE,  1'b0, 32'h0,        3, 1, 63, 32'hA1EEC3D4);
    add(1'b0, 2'b01, 1'b1, 32'hFE,  32'h0,         1'b0, 32'hFFFFA1EE, 2, 0, 63, 32'hA1EEC3D4);
    add(1'b0, 2'b00, 1'b0, 32'h103, 32'h0,         1'b1, 32'h0,        1, 0, 63, 32'hA1EEC3D4);

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
              lat, nwe, err, rdata, ready_ok, one_cycle);
      chk($sformatf("v%0d_ready", i), {31'b0, ready_ok}, 32'h1);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
      chk($sformatf("v%0d_we_pulses", i), 32'(nwe), 32'(vecs[i].nwe));
      chk($sformatf("v%0d_resp_one_cycle", i), {31'b0, one_cycle}, 32'h1);
      chk($sformatf("v%0d_mem_word", i), mem[vecs[i].idx], vecs[i].word);
    end

    // reset while the half store sits in WRITE: nothing may reach dmem
    @(negedge clk);
    req_valid = 1'b1;
    drive(1'b1, 2'b01, 1'b0, 32'h12, 32'h00007777);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rw_access_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    chk("rw_write_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw_we_forced_low", {31'b0, mem_we}, 32'h0);
    chk("rw_ready_in_reset", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    chk("rw_no_resp_in_reset", {31'b0, resp_valid}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_ready_after", {31'b0, req_ready}, 32'h1);
    chk("rw_no_resp_after", {31'b0, resp_valid}, 32'h0);
    chk("rw_word_kept", mem[4], 32'h55991234);

    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, nwe, err, rdata, ready_ok, one_cycle);
    chk("rw_readback", rdata, 32'h55991234);
    chk("rw_readback_lat", 32'(lat), 32'd2);

    // back-to-back loads with req_valid held
    nacc = 0; nrsp = 0;
    @(negedge clk);
    req_valid = 1'b1;
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    for (int t = 0; t < 14; t++) begin
      if (t > 0) @(negedge clk);
      if (resp_valid && nrsp < 3) begin
        rsp_cyc[nrsp] = t; rsp_dat[nrsp] = resp_rdata; nrsp++;
      end
      if (req_valid && req_ready && nacc < 3) begin
        acc_cyc[nacc] = t; nacc++;
        @(posedge clk);
        #1;
        if (nacc == 1) drive(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
        else if (nacc == 2) drive(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd3);
    chk("b2b_resps", 32'(nrsp), 32'd3);
    if (nacc == 3 && nrsp == 3) begin
      chk("b2b_acc0", 32'(acc_cyc[0]), 32'd0);
      chk("b2b_acc1", 32'(acc_cyc[1]), 32'd3);
      chk("b2b_acc2", 32'(acc_cyc[2]), 32'd6);
      chk("b2b_rsp0", 32'(rsp_cyc[0]), 32'd2);
      chk("b2b_rsp1", 32'(rsp_cyc[1]), 32'd5);
      chk("b2b_rsp2", 32'(rsp_cyc[2]), 32'd8);
      chk("b2b_dat0", rsp_dat[0], 32'h55991234);
      chk("b2b_dat1", rsp_dat[1], 32'h00000012);
      chk("b2b_dat2", rsp_dat[2], 32'h00005599);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
